// File: rtl/tlb_op_ctrl.sv
// Sequences CP0 TLB instructions (TLBP/TLBR/TLBWI/TLBWR) onto the TLB probe, read and write ports.
// Fixed 3-cycle occupancy per op; op_ready is high only in IDLE. Random is a free-running down-counter above Wired.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16,
  parameter int TLB_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic [1:0]           op_code,
  output logic                 op_ready,
  input  logic [TLB_WIDTH-1:0] cp0_index,
  input  logic [85:0]          cp0_entry,
  input  logic [TLB_WIDTH-1:0] cp0_wired,
  input  logic                 wired_we,
  output logic                 tlb_we,
  output logic [85:0]          tlb_config,
  output logic [TLB_WIDTH-1:0] tlb_config_index,
  output logic                 tlb_p,
  input  logic [31:0]          tlb_p_res_i,
  output logic [TLB_WIDTH-1:0] tlb_read_index,
  input  logic [85:0]          tlb_read_config_i,
  output logic                 res_index_we,
  output logic [31:0]          res_index,
  output logic                 res_entry_we,
  output logic [85:0]          res_entry,
  output logic                 flush_req,
  output logic [TLB_WIDTH-1:0] random
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROBE = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4,
    FLUSH = 3'd5
  } state_t;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [TLB_WIDTH-1:0] RAND_MAX = TLB_WIDTH'(TLB_ENTRIES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           op_q;
  logic [85:0]          entry_q;
  logic [TLB_WIDTH-1:0] index_q;
  logic [31:0]          res_index_q;
  logic [85:0]          res_entry_q;
  logic [TLB_WIDTH-1:0] random_q;
  logic                 accept;

  assign accept = op_valid & op_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // TLBWR captures Random as it stands in the accept cycle, not a later value.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 2'b00;
      entry_q <= '0;
      index_q <= '0;
    end else if (accept) begin
      op_q    <= op_code;
      entry_q <= cp0_entry;
      index_q <= (op_code == OP_TLBWR) ? random_q : cp0_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_index_q <= '0;
      res_entry_q <= '0;
    end else begin
      if (state == PROBE) begin
        res_index_q <= tlb_p_res_i;
      end
      if (state == READ) begin
        res_entry_q <= tlb_read_config_i;
      end
    end
  end

  // Wired >= TLB_ENTRIES-1 keeps Random pinned at the top via the wrap compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= RAND_MAX;
    end else if (wired_we) begin
      random_q <= RAND_MAX;
    end else if (random_q <= cp0_wired) begin
      random_q <= RAND_MAX;
    end else begin
      random_q <= random_q - 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    op_ready     = 1'b0;
    tlb_p        = 1'b0;
    tlb_we       = 1'b0;
    res_index_we = 1'b0;
    res_entry_we = 1'b0;
    flush_req    = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          case (op_code)
            OP_TLBP: state_nxt = PROBE;
            OP_TLBR: state_nxt = READ;
            default: state_nxt = WRITE;
          endcase
        end
      end
      PROBE: begin
        tlb_p     = 1'b1;
        state_nxt = RESP;
      end
      READ: begin
        state_nxt = RESP;
      end
      WRITE: begin
        tlb_we    = 1'b1;
        state_nxt = FLUSH;
      end
      RESP: begin
        res_index_we = (op_q == OP_TLBP);
        res_entry_we = (op_q == OP_TLBR);
        state_nxt    = IDLE;
      end
      FLUSH: begin
        flush_req = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign tlb_config       = entry_q;
  assign tlb_config_index = index_q;
  assign tlb_read_index   = index_q;
  assign res_index        = res_index_q;
  assign res_entry        = res_entry_q;
  assign random           = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: behavioural TLB array, strobe scoreboard, directed op and Random sequences.
module tb_tlb_op_ctrl;

  localparam int K_WE    = 0;
  localparam int K_PROBE = 1;
  localparam int K_RIDX  = 2;
  localparam int K_RENT  = 3;
  localparam int K_FLUSH = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [85:0] dat;
    logic [31:0] idx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready;
  logic [3:0]  cp0_index;
  logic [85:0] cp0_entry;
  logic [3:0]  cp0_wired;
  logic        wired_we;
  logic        tlb_we;
  logic [85:0] tlb_config;
  logic [3:0]  tlb_config_index;
  logic        tlb_p;
  logic [31:0] tlb_p_res_i;
  logic [3:0]  tlb_read_index;
  logic [85:0] tlb_read_config_i;
  logic        res_index_we;
  logic [31:0] res_index;
  logic        res_entry_we;
  logic [85:0] res_entry;
  logic        flush_req;
  logic [3:0]  random;

  int   cyc;
  int   errors;
  int   checks;
  exp_t sbq[$];

  logic [85:0] tlb_mem [16];
  logic [15:0] tlb_vld;

  tlb_op_ctrl #(.TLB_ENTRIES(16), .TLB_WIDTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .op_valid          (op_valid),
    .op_code           (op_code),
    .op_ready          (op_ready),
    .cp0_index         (cp0_index),
    .cp0_entry         (cp0_entry),
    .cp0_wired         (cp0_wired),
    .wired_we          (wired_we),
    .tlb_we            (tlb_we),
    .tlb_config        (tlb_config),
    .tlb_config_index  (tlb_config_index),
    .tlb_p             (tlb_p),
    .tlb_p_res_i       (tlb_p_res_i),
    .tlb_read_index    (tlb_read_index),
    .tlb_read_config_i (tlb_read_config_i),
    .res_index_we      (res_index_we),
    .res_index         (res_index),
    .res_entry_we      (res_entry_we),
    .res_entry         (res_entry),
    .flush_req         (flush_req),
    .random            (random)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural TLB array: write on strobe, combinational probe and read.
  always @(posedge clk) begin
    if (rst) begin
      tlb_vld <= '0;
      for (int i = 0; i < 16; i++) tlb_mem[i] <= '0;
    end else if (tlb_we) begin
      tlb_mem[tlb_config_index] <= tlb_config;
      tlb_vld[tlb_config_index] <= 1'b1;
    end
  end

  always_comb begin
    tlb_p_res_i = 32'h8000_0000;
    for (int i = 15; i >= 0; i--) begin
      if (tlb_vld[i] && (tlb_mem[i][70:52] == tlb_config[70:52])) tlb_p_res_i = 32'(i);
    end
  end

  assign tlb_read_config_i = tlb_mem[tlb_read_index];

  function automatic logic [85:0] mk_entry(input logic [18:0] vpn2, input logic [85:0] salt);
    logic [85:0] e;
    e = salt;
    e[70:52] = vpn2;
    return e;
  endfunction

  task automatic sb_check(input int kind, input logic [85:0] dat, input logic [31:0] idx);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: kind=%0d at cycle %0d with no expected event", kind, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.dat !== dat || e.idx !== idx) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d cyc=%0d dat=%h idx=%h, want kind=%0d cyc=%0d dat=%h idx=%h",
                 kind, cyc, dat, idx, e.kind, e.cyc, e.dat, e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tlb_we === 1'b1)       sb_check(K_WE, tlb_config, {28'b0, tlb_config_index});
    if (tlb_p === 1'b1)        sb_check(K_PROBE, tlb_config, 32'b0);
    if (res_index_we === 1'b1) sb_check(K_RIDX, 86'b0, res_index);
    if (res_entry_we === 1'b1) sb_check(K_RENT, res_entry, 32'b0);
    if (flush_req === 1'b1)    sb_check(K_FLUSH, 86'b0, 32'b0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input logic [85:0] dat, input logic [31:0] idx);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.dat  = dat;
    e.idx  = idx;
    sbq.push_back(e);
  endtask

  // Called just after a clock edge; returns in cycle T+3 with op_valid low.
  task automatic run_op(input logic [1:0] code, input logic [3:0] idx, input logic [85:0] ent,
                        input logic [31:0] exp_idx, input logic [85:0] exp_dat, input int hold);
    int t;
    chk("op_ready_at_T", {31'b0, op_ready}, 32'd1);
    op_code   = code;
    cp0_index = idx;
    cp0_entry = ent;
    op_valid  = 1'b1;
    t = cyc;
    case (code)
      2'b00: begin
        push(K_PROBE, t + 1, ent, 32'b0);
        push(K_RIDX, t + 2, 86'b0, exp_idx);
      end
      2'b01: push(K_RENT, t + 2, exp_dat, 32'b0);
      default: begin
        push(K_WE, t + 1, ent, exp_idx);
        push(K_FLUSH, t + 2, 86'b0, 32'b0);
      end
    endcase
    step();
    chk("op_ready_busy", {31'b0, op_ready}, 32'd0);
    if (hold == 0) op_valid = 1'b0;
    step();
    if (hold <= 1) op_valid = 1'b0;
    step();
    op_valid = 1'b0;
    chk("op_ready_T3", {31'b0, op_ready}, 32'd1);
  endtask

  logic [85:0] e1, e2, e3, key_hit, key_miss;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0; errors = 0; checks = 0;
    rst = 1'b1; op_valid = 1'b0; op_code = 2'b00; cp0_index = '0;
    cp0_entry = '0; cp0_wired = 4'd0; wired_we = 1'b0;
    e1       = mk_entry(19'h01234, 86'h1_2345_6789_ABCD_EF01_2345);
    e2       = mk_entry(19'h00ABC, 86'h2_F0F0_0F0F_5555_AAAA_C3C3);
    e3       = mk_entry(19'h05555, 86'h3_1111_2222_3333_4444_5555);
    key_hit  = mk_entry(19'h01234, 86'h0_0000_0000_DEAD_BEEF_0000);
    key_miss = mk_entry(19'h07777, 86'h0_0000_0000_DEAD_BEEF_0000);

    repeat (3) step();
    rst = 1'b0;
    chk("rst_op_ready", {31'b0, op_ready}, 32'd1);
    chk("rst_random", {28'b0, random}, 32'd15);
    chk("rst_strobes", {27'b0, tlb_we, tlb_p, res_index_we, res_entry_we, flush_req}, 32'd0);
    chk("rst_res_index", res_index, 32'd0);
    for (int i = 14; i >= 0; i--) begin
      step();
      chk("random_count", {28'b0, random}, 32'(i));
    end
    step();
    chk("random_wrap", {28'b0, random}, 32'd15);

    run_op(2'b10, 4'd5, e1, 32'd5, 86'b0, 0);
    run_op(2'b10, 4'd9, e2, 32'd9, 86'b0, 0);
    run_op(2'b00, 4'd0, key_hit, 32'd5, 86'b0, 0);
    run_op(2'b00, 4'd0, key_miss, 32'h8000_0000, 86'b0, 0);
    run_op(2'b01, 4'd5, e1, 32'b0, e1, 2);
    run_op(2'b01, 4'd9, e1, 32'b0, e2, 1);

    cp0_wired = 4'd12;
    wired_we  = 1'b1;
    step();
    wired_we = 1'b0;
    chk("wired_we_force", {28'b0, random}, 32'd15);
    step(); chk("wired_cnt14", {28'b0, random}, 32'd14);
    step(); chk("wired_cnt13", {28'b0, random}, 32'd13);
    step(); chk("wired_cnt12", {28'b0, random}, 32'd12);
    step(); chk("wired_wrap15", {28'b0, random}, 32'd15);
    step(); chk("wired_cnt14b", {28'b0, random}, 32'd14);
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    chk("wired_we_mid", {28'b0, random}, 32'd15);
    step();
    chk("random_at_wr", {28'b0, random}, 32'd14);
    run_op(2'b11, 4'd3, e3, 32'd14, 86'b0, 0);
    run_op(2'b01, 4'd14, e1, 32'b0, e3, 0);

    cp0_wired = 4'd15;
    step();
    step(); chk("wired_max_a", {28'b0, random}, 32'd15);
    step(); chk("wired_max_b", {28'b0, random}, 32'd15);
    step(); chk("wired_max_c", {28'b0, random}, 32'd15);
    cp0_wired = 4'd0;

    op_code   = 2'b00;
    cp0_entry = key_hit;
    op_valid  = 1'b1;
    push(K_PROBE, cyc + 1, key_hit, 32'b0);
    step();
    op_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_op_ready", {31'b0, op_ready}, 32'd1);
    chk("midrst_random", {28'b0, random}, 32'd15);
    chk("midrst_res_index", res_index, 32'd0);
    repeat (4) step();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
